tm_run_controller: RTL and testbench

Sequencer between the chip pins and the `TuringMachine` core. It synchronizes and edge-detects the raw Next/Done push-buttons and loads 4-bit symbols onto the tape one per Next press. On Done it clears the machine and runs it to halt or step-limit, then reports completion. It replaces the direct pin-to-core wiring inside `my_chip`.

---
 rtl/tm_run_controller.sv | 127 ++++++++++++
 tb/tb_tm_run_controller.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm_run_controller.sv
// tm_run_controller: button-driven tape loader and run sequencer for the TuringMachine core.
// Define TM_CTRL_SINGLE_STEP_EN to step the core once per Next press and allow Done to abort a run.
module tm_run_controller #(
  parameter int DATA_W = 4,
  parameter int TAPE_LEN = 64,
  parameter int MAX_STEPS = 1024,
  localparam int ADDR_W = $clog2(TAPE_LEN),
  localparam int STEP_W = $clog2(MAX_STEPS + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              next_in,
  input  logic              done_in,
  output logic              tape_we,
  output logic [ADDR_W-1:0] tape_addr,
  output logic [DATA_W-1:0] tape_wdata,
  output logic              tm_clear,
  output logic              tm_step,
  input  logic              tm_halted,
  output logic [ADDR_W:0]   load_count,
  output logic              overflow,
  output logic              compute_done,
  output logic              timeout
);
  typedef enum logic [2:0] {S_LOAD, S_CLEAR, S_RUN, S_DONE, S_TIMEOUT} state_t;
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(TAPE_LEN);
  localparam logic [STEP_W-1:0] LAST = STEP_W'(MAX_STEPS - 1);
  state_t state_q;
  logic [DATA_W+1:0] sync1_q, sync2_q;
  logic next_prev_q, done_prev_q;
  logic tape_we_q, tm_clear_q, overflow_q, compute_done_q, timeout_q;
  logic [ADDR_W-1:0] tape_addr_q;
  logic [DATA_W-1:0] tape_wdata_q;
  logic [ADDR_W:0] load_count_q;
  logic [STEP_W-1:0] step_q;
  logic next_p, done_p;
  assign next_p = sync2_q[DATA_W] & ~next_prev_q;
  assign done_p = sync2_q[DATA_W+1] & ~done_prev_q;
`ifdef TM_CTRL_SINGLE_STEP_EN
  assign tm_step = (state_q == S_RUN) && next_p && !tm_halted;
`else
  assign tm_step = (state_q == S_RUN) && !tm_halted;
`endif
  assign tape_we = tape_we_q;
  assign tape_addr = tape_addr_q;
  assign tape_wdata = tape_wdata_q;
  assign tm_clear = tm_clear_q;
  assign load_count = load_count_q;
  assign overflow = overflow_q;
  assign compute_done = compute_done_q;
  assign timeout = timeout_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOAD;
      sync1_q <= '0;
      sync2_q <= '0;
      next_prev_q <= 1'b0;
      done_prev_q <= 1'b0;
      tape_we_q <= 1'b0;
      tape_addr_q <= '0;
      tape_wdata_q <= '0;
      tm_clear_q <= 1'b0;
      load_count_q <= '0;
      overflow_q <= 1'b0;
      compute_done_q <= 1'b0;
      timeout_q <= 1'b0;
      step_q <= '0;
    end else begin
      sync1_q <= {done_in, next_in, data_in};
      sync2_q <= sync1_q;
      next_prev_q <= sync2_q[DATA_W];
      done_prev_q <= sync2_q[DATA_W+1];
      tape_we_q <= 1'b0;
      tm_clear_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (next_p && load_count_q < FULL) begin
            tape_we_q <= 1'b1;
            tape_addr_q <= load_count_q[ADDR_W-1:0];
            tape_wdata_q <= sync2_q[DATA_W-1:0];
            load_count_q <= load_count_q + 1'b1;
          end else if (next_p) begin
            overflow_q <= 1'b1;
          end
          if (done_p) state_q <= S_CLEAR;
        end
        // First CLEAR cycle raises tm_clear, second hands over to RUN.
        S_CLEAR: begin
          tm_clear_q <= !tm_clear_q;
          step_q <= '0;
          if (tm_clear_q) state_q <= S_RUN;
        end
        S_RUN: begin
          if (tm_halted) begin
            state_q <= S_DONE;
            compute_done_q <= 1'b1;
          end
`ifdef TM_CTRL_SINGLE_STEP_EN
          else if (done_p) begin
            state_q <= S_LOAD;
            load_count_q <= '0;
            overflow_q <= 1'b0;
          end
`endif
          else if (tm_step) begin
            step_q <= step_q + 1'b1;
            if (step_q == LAST) begin
              state_q <= S_TIMEOUT;
              timeout_q <= 1'b1;
            end
          end
        end
        S_DONE, S_TIMEOUT: begin
          if (done_p) begin
            state_q <= S_LOAD;
            load_count_q <= '0;
            overflow_q <= 1'b0;
            compute_done_q <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_tm_run_controller.sv
// tb_tm_run_controller: directed and randomized checks of loading, run, halt, watchdog and overflow.
module tb_tm_run_controller;
  localparam int DW = 4;
  localparam int TL = 64;
  localparam int MS = 16;
  localparam int AW = 6;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic next_in = 1'b0;
  logic done_in = 1'b0;
  logic tm_halted = 1'b0;
  logic tape_we, tm_clear, tm_step, overflow, compute_done, timeout;
  logic [AW-1:0] tape_addr;
  logic [DW-1:0] tape_wdata;
  logic [AW:0] load_count;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nsteps = 0;
  int nclear = 0;
  int nwr = 0;
  int halt_after = -1;
  int last_step = -1;
  int halt_cyc = -1;
  int cd_cyc = -1;
  int to_cyc = -1;
  int clear_cyc = -1;
  int last_addr = -1;
  logic [DW-1:0] tape [TL];
  logic [DW-1:0] exp_q [$];

  tm_run_controller #(.DATA_W(DW), .TAPE_LEN(TL), .MAX_STEPS(MS)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .next_in(next_in), .done_in(done_in),
    .tape_we(tape_we), .tape_addr(tape_addr), .tape_wdata(tape_wdata), .tm_clear(tm_clear),
    .tm_step(tm_step), .tm_halted(tm_halted), .load_count(load_count), .overflow(overflow),
    .compute_done(compute_done), .timeout(timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // The core model halts once it has consumed halt_after steps (never if negative).
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    tm_halted = (halt_after >= 0) && (nsteps >= halt_after);
    if (tm_halted && halt_cyc < 0) halt_cyc = cyc;
    #1;
    if (tape_we) begin
      tape[tape_addr] = tape_wdata;
      last_addr = int'(tape_addr);
      nwr++;
    end
    if (tm_step) begin
      nsteps++;
      last_step = cyc;
    end
    if (tm_clear) begin
      nclear++;
      clear_cyc = cyc;
    end
    if (compute_done && cd_cyc < 0) cd_cyc = cyc;
    if (timeout && to_cyc < 0) to_cyc = cyc;
  endtask

  task automatic model_clear();
    exp_q.delete();
    nwr = 0;
    nsteps = 0;
    nclear = 0;
    halt_after = -1;
    halt_cyc = -1;
    cd_cyc = -1;
    to_cyc = -1;
    last_step = -1;
  endtask

  task automatic press(input logic n, input logic d, input logic [DW-1:0] v, input int hold);
    next_in = n;
    done_in = d;
    data_in = v;
    if (n && exp_q.size() < TL) exp_q.push_back(v);
    repeat (hold) tick();
    next_in = 1'b0;
    done_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic load_random(input int k);
    for (int i = 0; i < k; i++) press(1'b1, 1'b0, DW'($urandom_range(0, 15)), int'($urandom_range(1, 3)));
  endtask

  task automatic check_tape(input string tag);
    int errs = 0;
    for (int i = 0; i < exp_q.size(); i++) if (tape[i] !== exp_q[i]) errs++;
    chk({tag, "_tape"}, errs, 0);
    chk({tag, "_nwr"}, nwr, exp_q.size());
    chk({tag, "_load_count"}, 32'(load_count), exp_q.size());
  endtask

  // Drives the run forward until the wanted flag rises (free-running or by Next presses).
  task automatic run_until(input bit want_timeout, input string tag);
    for (int i = 0; i < 200; i++) begin
      if (want_timeout ? timeout : compute_done) break;
`ifdef TM_CTRL_SINGLE_STEP_EN
      next_in = 1'b1;
      tick();
      next_in = 1'b0;
      repeat (3) tick();
`else
      tick();
`endif
    end
    chk({tag, "_reached"}, want_timeout ? 32'(timeout) : 32'(compute_done), 1);
  endtask

  initial begin
    logic [DW-1:0] d;
    int w0;
    repeat (3) tick();
    chk("rst_tape_we", 32'(tape_we), 0);
    chk("rst_tm_clear", 32'(tm_clear), 0);
    chk("rst_tm_step", 32'(tm_step), 0);
    chk("rst_load_count", 32'(load_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_compute_done", 32'(compute_done), 0);
    chk("rst_timeout", 32'(timeout), 0);
    reset = 1'b1;
    tick();

    load_random(3);
    chk("pre_reset_count", 32'(load_count), 3);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_count", 32'(load_count), 0);
    chk("async_rst_we", 32'(tape_we), 0);
    tick();
    reset = 1'b1;
    tick();
    model_clear();
    d = DW'($urandom_range(0, 15));
    press(1'b1, 1'b0, d, 2);
    chk("after_rst_addr", last_addr, 0);
    check_tape("after_rst");

    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    model_clear();
    next_in = 1'b1;
    data_in = 4'd1;
    exp_q.push_back(4'd1);
    tick();
    chk("we_lat1", 32'(tape_we), 0);
    tick();
    chk("we_lat2", 32'(tape_we), 0);
    tick();
    chk("we_lat3", 32'(tape_we), 1);
    chk("we_lat3_addr", 32'(tape_addr), 0);
    next_in = 1'b0;
    repeat (3) tick();
    for (int i = 2; i <= 5; i++) press(1'b1, 1'b0, DW'(i), 2);
    check_tape("five");
    halt_after = 10;
    done_in = 1'b1;
    tick();
    tick();
    tick();
    chk("clear_lat3", 32'(tm_clear), 0);
    tick();
    chk("clear_lat4", 32'(tm_clear), 1);
    chk("clear_no_step", 32'(tm_step), 0);
    tick();
`ifndef TM_CTRL_SINGLE_STEP_EN
    chk("first_step", 32'(tm_step), 1);
`endif
    chk("clear_one_cycle", 32'(tm_clear), 0);
    done_in = 1'b0;
    run_until(1'b0, "halt10");
    chk("halt10_steps", nsteps, 10);
    chk("halt10_clears", nclear, 1);
    chk("halt10_done_cycle", cd_cyc, halt_cyc + 1);
    chk("halt10_timeout", 32'(timeout), 0);
    chk("halt10_load_kept", 32'(load_count), 5);
    press(1'b0, 1'b1, '0, 2);
    chk("halt10_back_cd", 32'(compute_done), 0);
    chk("halt10_back_count", 32'(load_count), 0);

    model_clear();
    load_random(int'($urandom_range(1, 6)));
    check_tape("to_load");
    press(1'b0, 1'b1, '0, 2);
    run_until(1'b1, "wdog");
    chk("wdog_steps", nsteps, MS);
    chk("wdog_compute_done", 32'(compute_done), 0);
    chk("wdog_timeout_cycle", to_cyc, last_step + 1);
    repeat (5) tick();
    chk("wdog_no_more_steps", nsteps, MS);
    press(1'b0, 1'b1, '0, 2);
    chk("wdog_back_timeout", 32'(timeout), 0);
    chk("wdog_back_count", 32'(load_count), 0);

    model_clear();
    load_random(TL);
    check_tape("full");
    chk("full_no_overflow", 32'(overflow), 0);
    w0 = nwr;
    press(1'b1, 1'b0, DW'($urandom_range(0, 15)), 2);
    chk("ovf_no_write", nwr, w0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(load_count), TL);
    halt_after = 3;
    press(1'b0, 1'b1, '0, 2);
    run_until(1'b0, "ovf_run");
    chk("ovf_sticky", 32'(overflow), 1);
    press(1'b0, 1'b1, '0, 2);
    chk("ovf_cleared", 32'(overflow), 0);

    model_clear();
    load_random(2);
    d = DW'($urandom_range(0, 15));
    halt_after = 1;
    press(1'b1, 1'b1, d, 2);
    chk("both_addr", last_addr, 2);
    check_tape("both");
    chk("both_clear", nclear, 1);
    run_until(1'b0, "both_run");
    press(1'b0, 1'b1, '0, 2);

    model_clear();
    d = DW'($urandom_range(0, 15));
    next_in = 1'b1;
    data_in = d;
    exp_q.push_back(d);
    repeat (10) tick();
    next_in = 1'b0;
    tick();
    next_in = 1'b1;
    exp_q.push_back(d);
    repeat (10) tick();
    next_in = 1'b0;
    repeat (4) tick();
    check_tape("held");

`ifdef TM_CTRL_SINGLE_STEP_EN
    model_clear();
    load_random(2);
    press(1'b0, 1'b1, '0, 2);
    repeat (4) tick();
    chk("ss_idle", nsteps, 0);
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, '0, int'($urandom_range(2, 6)));
    chk("ss_three", nsteps, 3);
    press(1'b0, 1'b1, '0, 2);
    chk("ss_abort_count", 32'(load_count), 0);
    chk("ss_abort_done", 32'(compute_done), 0);
    press(1'b1, 1'b0, 4'd7, 2);
    chk("ss_abort_reload_addr", last_addr, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
